// File: rtl/ss_pkg.sv
// Shared types and constants for the source-read channel and its FIFO.
package ss_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_REQ,
      S_BUS,
      S_DRAIN,
      S_DONE
   } ss_state_e;

   localparam logic [2:0] SS_ERR_OK  = 3'd0;
   localparam logic [2:0] SS_ERR_BUS = 3'd1;
   localparam logic [2:0] SS_ERR_RTY = 3'd2;

   localparam logic [1:0] SS_W_ADR = 2'd2;
   localparam logic [1:0] SS_W_CNT = 2'd3;

   localparam int unsigned SS_BEAT_W = 64;

   // Bytes to 64-bit beats, rounded up; the result is kept to 13 bits.
   function automatic logic [12:0] ss_beats(input logic [15:0] cnt);
      logic [16:0] sum;
      sum = {1'b0, cnt} + 17'd7;
      return sum[15:3];
   endfunction

endpackage

// File: rtl/ss_fifo.sv
// Synchronous 64-bit FIFO with flush, empty flag and free-entry count.
module ss_fifo
   import ss_pkg::*;
#(
   parameter int unsigned AW = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 push_i,
   input  logic [SS_BEAT_W-1:0] din_i,
   input  logic                 pop_i,
   input  logic                 flush_i,
   output logic [SS_BEAT_W-1:0] dout_o,
   output logic                 empty_o,
   output logic [AW:0]          free_o
);

   localparam int unsigned DEPTH   = 2 ** AW;
   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

   logic [SS_BEAT_W-1:0] mem_q [DEPTH];
   logic [AW:0]          wr_q, wr_d;
   logic [AW:0]          rd_q, rd_d;
   logic [AW:0]          count;
   logic                 full;
   logic                 do_push;
   logic                 do_pop;

   assign count   = wr_q - rd_q;
   assign empty_o = (count == '0);
   assign full    = (count == DEPTH_W);
   assign free_o  = DEPTH_W - count;
   assign do_push = push_i && !full && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;
   assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (flush_i) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + (AW + 1)'(1);
         if (do_pop)  rd_d = rd_q + (AW + 1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/ss_rd_chan.sv
// Per-channel source-read engine: slot capture, Wishbone burst fetch, FIFO out.
// Optional fetch-duration counter on cyc_cnt when SS_RD_PERF_CNT_EN is defined.
module ss_rd_chan
   import ss_pkg::*;
#(
   parameter int unsigned BURST   = 4,
   parameter int unsigned FIFO_AW = 3,
   parameter int unsigned RTY_MAX = 15
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 ss_we,
   input  logic [1:0]           ss_adr,
   input  logic [31:0]          ss_dat,
   input  logic [23:0]          ss_dc,
   input  logic                 ss_done,
   output logic                 c_done,
   output logic [2:0]           err,
   output logic                 wbm_cyc_o,
   output logic                 wbm_stb_o,
   output logic                 wbm_we_o,
   output logic                 wbm_cab_o,
   output logic [3:0]           wbm_sel_o,
   output logic [31:0]          wbm_adr_o,
   input  logic [31:0]          wbm_dat_i,
   input  logic [31:0]          wbm_dat64_i,
   input  logic                 wbm_ack_i,
   input  logic                 wbm_err_i,
   input  logic                 wbm_rty_i,
   output logic [SS_BEAT_W-1:0] dout,
   output logic                 dout_valid,
   input  logic                 dout_ready,
   output logic [31:0]          cyc_cnt
);

   localparam int unsigned RW = $clog2(RTY_MAX + 2);
   localparam int unsigned BW = $clog2(BURST + 1);

   ss_state_e     state_q, state_d;
   logic [28:0]   adr_q, adr_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [12:0]   rem_q, rem_d;
   logic [BW-1:0] blen_q, blen_d;
   logic [RW-1:0] rty_q, rty_d;
   logic [2:0]    err_q, err_d;

   logic          push;
   logic          flush;
   logic          bus_live;
   logic          fifo_empty;
   logic [FIFO_AW:0] fifo_free;
   logic [12:0]   need;
   logic [12:0]   load_beats;
   logic [RW-1:0] rty_inc;
   logic          unused_dc;

   assign unused_dc  = ^ss_dc;
   assign load_beats = ss_beats(cnt_q);
   assign need       = (rem_q < 13'(BURST)) ? rem_q : 13'(BURST);
   assign rty_inc    = rty_q + RW'(1);
   // A cancel pulse removes the bus request combinationally, in the same cycle.
   assign bus_live   = (state_q == S_BUS) && !ss_done;

   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      blen_d  = blen_q;
      rty_d   = rty_q;
      err_d   = err_q;
      push    = 1'b0;
      flush   = 1'b0;
      if (ss_done && state_q != S_IDLE) begin
         flush   = 1'b1;
         err_d   = SS_ERR_OK;
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (ss_we) begin
                  case (ss_adr)
                     SS_W_ADR: adr_d = ss_dat[31:3];
                     SS_W_CNT: begin
                        cnt_d   = ss_dat[15:0];
                        state_d = S_LOAD;
                     end
                     default: ;
                  endcase
               end
            end
            S_LOAD: begin
               rem_d   = load_beats;
               rty_d   = '0;
               state_d = (load_beats == 13'd0) ? S_DONE : S_REQ;
            end
            S_REQ: begin
               // Reserving the whole burst up front means pushes can never overflow.
               if (32'(fifo_free) >= 32'(need)) begin
                  blen_d  = BW'(need);
                  state_d = S_BUS;
               end
            end
            S_BUS: begin
               if (wbm_err_i) begin
                  err_d   = SS_ERR_BUS;
                  flush   = 1'b1;
                  state_d = S_DONE;
               end else if (wbm_rty_i) begin
                  rty_d = rty_inc;
                  if (32'(rty_inc) > RTY_MAX) begin
                     err_d   = SS_ERR_RTY;
                     flush   = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     state_d = S_REQ;
                  end
               end else if (wbm_ack_i) begin
                  push   = 1'b1;
                  adr_d  = adr_q + 29'd1;
                  rem_d  = rem_q - 13'd1;
                  blen_d = blen_q - BW'(1);
                  rty_d  = '0;
                  if (blen_q == BW'(1)) state_d = (rem_q == 13'd1) ? S_DRAIN : S_REQ;
               end
            end
            S_DRAIN: begin
               if (fifo_empty) state_d = S_DONE;
            end
            S_DONE: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= S_IDLE;
         adr_q   <= '0;
         cnt_q   <= '0;
         rem_q   <= '0;
         blen_q  <= '0;
         rty_q   <= '0;
         err_q   <= SS_ERR_OK;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         blen_q  <= blen_d;
         rty_q   <= rty_d;
         err_q   <= err_d;
      end
   end

   ss_fifo #(.AW(FIFO_AW)) u_fifo (
      .clk_i   (wb_clk_i),
      .rst_i   (wb_rst_i),
      .push_i  (push),
      .din_i   ({wbm_dat64_i, wbm_dat_i}),
      .pop_i   (dout_ready),
      .flush_i (flush),
      .dout_o  (dout),
      .empty_o (fifo_empty),
      .free_o  (fifo_free)
   );

   assign dout_valid = !fifo_empty;
   assign c_done     = (state_q == S_DONE);
   assign err        = err_q;
   assign wbm_cyc_o  = bus_live;
   assign wbm_stb_o  = bus_live;
   assign wbm_cab_o  = bus_live;
   assign wbm_we_o   = 1'b0;
   assign wbm_sel_o  = 4'b1111;
   assign wbm_adr_o  = {adr_q, 3'b000};

`ifdef SS_RD_PERF_CNT_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (state_q == S_IDLE && state_d == S_LOAD) begin
         perf_d = '0;
      end else if (state_q inside {S_LOAD, S_REQ, S_BUS, S_DRAIN}) begin
         perf_d = perf_q + 32'd1;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) perf_q <= '0;
      else          perf_q <= perf_d;
   end

   assign cyc_cnt = perf_q;
`else
   assign cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_ss_rd_chan.sv
// Randomised bench for ss_rd_chan: Wishbone slave model plus queue-based reference.
module tb_ss_rd_chan;
   import ss_pkg::*;

   localparam int unsigned BURST   = 4;
   localparam int unsigned FIFO_AW = 3;
   localparam int unsigned RTY_MAX = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ss_we = 1'b0;
   logic [1:0]  ss_adr = '0;
   logic [31:0] ss_dat = '0;
   logic [23:0] ss_dc = 24'h000400;
   logic        ss_done = 1'b0;
   logic        c_done;
   logic [2:0]  err;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_i = '0, wbm_dat64_i = '0;
   logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0, wbm_rty_i = 1'b0;
   logic [63:0] dout;
   logic        dout_valid;
   logic        dout_ready = 1'b0;
   logic [31:0] cyc_cnt;

   ss_rd_chan #(.BURST(BURST), .FIFO_AW(FIFO_AW), .RTY_MAX(RTY_MAX)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .ss_we(ss_we), .ss_adr(ss_adr), .ss_dat(ss_dat), .ss_dc(ss_dc), .ss_done(ss_done),
      .c_done(c_done), .err(err),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_cab_o(wbm_cab_o),
      .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o),
      .wbm_dat_i(wbm_dat_i), .wbm_dat64_i(wbm_dat64_i),
      .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .cyc_cnt(cyc_cnt)
   );

   always #5 clk = ~clk;

   int n_pass = 0, n_total = 0;
   int ack_pct = 100, ready_pct = 100, err_beat = -1, rty_left = 0;
   int ack_cnt = 0, run_len = 0;
   logic cyc_prev = 1'b0;
   logic [31:0] acked_adr[$];
   logic [31:0] starts[$];
   int          runs[$];
   logic [63:0] popped[$];

   function automatic logic [63:0] mem_word(input logic [31:0] a);
      return {a ^ 32'hC3A5_0F96, ~a + 32'h0101_0101};
   endfunction

   // Slave, consumer and bus monitor all act on the falling edge.
   always @(negedge clk) begin
      wbm_ack_i  = 1'b0;
      wbm_err_i  = 1'b0;
      wbm_rty_i  = 1'b0;
      dout_ready = (int'($urandom_range(99)) < ready_pct);
      if (!rst) begin
         if (dout_valid && dout_ready) popped.push_back(dout);
         if (wbm_cyc_o && !cyc_prev) begin
            starts.push_back(wbm_adr_o);
            run_len = 0;
         end
         if (!wbm_cyc_o && cyc_prev) runs.push_back(run_len);
         if (wbm_cyc_o && wbm_stb_o) begin
            if (rty_left > 0) begin
               wbm_rty_i = 1'b1;
               rty_left--;
            end else if (err_beat == ack_cnt) begin
               wbm_err_i = 1'b1;
            end else if (int'($urandom_range(99)) < ack_pct) begin
               wbm_ack_i = 1'b1;
               {wbm_dat64_i, wbm_dat_i} = mem_word(wbm_adr_o);
               acked_adr.push_back(wbm_adr_o);
               ack_cnt++;
               run_len++;
            end
         end
      end
      cyc_prev = wbm_cyc_o;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      acked_adr.delete();
      starts.delete();
      runs.delete();
      popped.delete();
      ack_cnt = 0;
   endtask

   task automatic slot_wr(input logic [1:0] a, input logic [31:0] d);
      ss_we  = 1'b1;
      ss_adr = a;
      ss_dat = d;
      tick();
      ss_we  = 1'b0;
   endtask

   task automatic start(input logic [31:0] src, input logic [15:0] cnt);
      slot_wr(2'd0, $urandom);
      slot_wr(2'd1, $urandom);
      slot_wr(SS_W_ADR, src);
      slot_wr(SS_W_CNT, {16'($urandom), cnt});
   endtask

   task automatic wait_done(input int budget, input string tag);
      int k;
      k = 0;
      while (!c_done && k < budget) begin
         tick();
         k++;
      end
      check({tag, "_done"}, 64'(c_done), 64'd1);
   endtask

   task automatic release_chan(input string tag);
      ss_done = 1'b1;
      tick();
      ss_done = 1'b0;
      check({tag, "_rel_cdone"}, 64'(c_done), 64'd0);
      check({tag, "_rel_err"}, 64'(err), 64'd0);
   endtask

   task automatic wait_cyc(input string tag);
      int k;
      k = 0;
      while (!wbm_cyc_o && k < 100) begin
         tick();
         k++;
      end
      check({tag, "_cyc_up"}, 64'(wbm_cyc_o), 64'd1);
   endtask

   // Expected beats, addresses, data and burst shapes from byte count and source.
   task automatic check_fetch(input string tag, input logic [31:0] src, input int cnt,
                              input bit chk_runs);
      int nb, left;
      int exp_runs[$];
      logic [31:0] base, ea;
      bit ok_a, ok_d, ok_r;
      nb   = (cnt + 7) / 8;
      base = {src[31:3], 3'b000};
      left = nb;
      while (left > 0) begin
         exp_runs.push_back(left < int'(BURST) ? left : int'(BURST));
         left -= int'(BURST);
      end
      ok_a = 1'b1;
      ok_d = 1'b1;
      for (int i = 0; i < nb; i++) begin
         ea = base + 32'(8 * i);
         if (i < acked_adr.size() && acked_adr[i] !== ea) ok_a = 1'b0;
         if (i < popped.size() && popped[i] !== mem_word(ea)) ok_d = 1'b0;
      end
      check({tag, "_nacks"}, 64'(acked_adr.size()), 64'(nb));
      check({tag, "_npops"}, 64'(popped.size()), 64'(nb));
      check({tag, "_adr_seq"}, 64'(ok_a), 64'd1);
      check({tag, "_data_seq"}, 64'(ok_d), 64'd1);
      check({tag, "_err"}, 64'(err), 64'd0);
      if (chk_runs) begin
         ok_r = (runs.size() == exp_runs.size());
         for (int i = 0; i < exp_runs.size() && i < runs.size(); i++)
            if (runs[i] != exp_runs[i]) ok_r = 1'b0;
         check({tag, "_bursts"}, 64'(ok_r), 64'd1);
      end
   endtask

   initial begin
      logic [31:0] src;
      int          cnt;

      repeat (3) tick();
      rst = 1'b0;
      check("rst_cdone", 64'(c_done), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_cyc", 64'(wbm_cyc_o), 64'd0);
      check("rst_stb", 64'(wbm_stb_o), 64'd0);
      check("rst_valid", 64'(dout_valid), 64'd0);
      check("rst_dout", dout, 64'd0);
      check("rst_adr", 64'(wbm_adr_o), 64'd0);
      check("rst_cyccnt", 64'(cyc_cnt), 64'd0);

      // Basic single burst
      clear_logs();
      start(32'h0000_1000, 16'd32);
      wait_done(200, "basic");
      check_fetch("basic", 32'h0000_1000, 32, 1'b1);
`ifdef SS_RD_PERF_CNT_EN
      check("basic_cyccnt", 64'(cyc_cnt), 64'd8);
`else
      check("basic_cyccnt", 64'(cyc_cnt), 64'd0);
`endif
      release_chan("basic");

      // Rounding and chunking 44 bytes -> 4 + 2 beats
      clear_logs();
      start(32'h0000_1000, 16'd44);
      wait_done(200, "chunk");
      check_fetch("chunk", 32'h0000_1000, 44, 1'b1);
      check("chunk_nstart", 64'(starts.size()), 64'd2);
      if (starts.size() == 2) check("chunk_start2", 64'(starts[1]), 64'h1020);
      release_chan("chunk");

      // Zero length
      clear_logs();
      start(32'h0000_2000, 16'd0);
      check("zl_cdone_early", 64'(c_done), 64'd0);
      tick();
      check("zl_cdone", 64'(c_done), 64'd1);
      repeat (3) tick();
      check("zl_no_cyc", 64'(starts.size()), 64'd0);
      release_chan("zl");

      // Back-pressure: FIFO holds 8 beats while consumer stalls
      clear_logs();
      ready_pct = 0;
      start(32'h0000_2000, 16'd128);
      repeat (40) tick();
      check("bp_acks", 64'(acked_adr.size()), 64'd8);
      check("bp_cyc_low", 64'(wbm_cyc_o), 64'd0);
      check("bp_valid", 64'(dout_valid), 64'd1);
      ready_pct = 100;
      wait_done(400, "bp");
      check_fetch("bp", 32'h0000_2000, 128, 1'b1);
      release_chan("bp");

      // Bus error on the third response
      clear_logs();
      ready_pct = 0;
      err_beat  = 2;
      start(32'h0000_3000, 16'd64);
      wait_done(200, "berr");
      check("berr_err", 64'(err), 64'd1);
      check("berr_cyc", 64'(wbm_cyc_o), 64'd0);
      check("berr_valid", 64'(dout_valid), 64'd0);
      check("berr_acks", 64'(acked_adr.size()), 64'd2);
      err_beat  = -1;
      ready_pct = 100;
      release_chan("berr");

      // Retry limit: 16 consecutive retries abort
      clear_logs();
      rty_left = 16;
      start(32'h0000_4000, 16'd32);
      wait_done(400, "rty16");
      check("rty16_err", 64'(err), 64'd2);
      check("rty16_acks", 64'(acked_adr.size()), 64'd0);
      rty_left = 0;
      release_chan("rty16");

      // Fifteen retries are tolerated
      clear_logs();
      rty_left = 15;
      start(32'h0000_4100, 16'd32);
      wait_done(400, "rty15");
      check_fetch("rty15", 32'h0000_4100, 32, 1'b0);
      rty_left = 0;
      release_chan("rty15");

      // Cancel mid-burst
      clear_logs();
      start(32'h0000_5000, 16'd128);
      wait_cyc("cx");
      check("cx_sel", 64'(wbm_sel_o), 64'hF);
      check("cx_we", 64'(wbm_we_o), 64'd0);
      check("cx_cab", 64'(wbm_cab_o), 64'd1);
      ss_done = 1'b1;
      #1;
      check("cx_cyc_drop", 64'(wbm_cyc_o), 64'd0);
      tick();
      ss_done = 1'b0;
      check("cx_valid", 64'(dout_valid), 64'd0);
      check("cx_cdone", 64'(c_done), 64'd0);
      repeat (5) tick();
      check("cx_idle_cyc", 64'(wbm_cyc_o), 64'd0);
      clear_logs();
      start(32'h0000_5800, 16'd32);
      wait_done(200, "cx_after");
      check_fetch("cx_after", 32'h0000_5800, 32, 1'b1);
      release_chan("cx_after");

      // Reset mid-burst
      start(32'h0000_6000, 16'd128);
      wait_cyc("mrst");
      rst = 1'b1;
      tick();
      check("mrst_cyc", 64'(wbm_cyc_o), 64'd0);
      check("mrst_valid", 64'(dout_valid), 64'd0);
      check("mrst_cdone", 64'(c_done), 64'd0);
      rst = 1'b0;
      tick();

      // Randomised transfers, first one wrapping the address space
      for (int it = 0; it < 8; it++) begin
         src       = (it == 0) ? 32'hFFFF_FFE0 : $urandom;
         cnt       = (it == 0) ? 64 : int'($urandom_range(200));
         ack_pct   = int'($urandom_range(100, 40));
         ready_pct = int'($urandom_range(100, 30));
         clear_logs();
         start(src, 16'(cnt));
         wait_done(4000, $sformatf("rnd%0d", it));
         check_fetch($sformatf("rnd%0d", it), src, cnt, 1'b1);
         release_chan($sformatf("rnd%0d", it));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ss_rd_chan.md
Name: ss_rd_chan

Overview:
- Per-channel source-read engine sitting directly downstream of the DMA descriptor controller.
- Receives the four 32-bit slot words written on the ss_we/ss_adr/ss_dat strobe interface and fetches the source buffer over a 64-bit Wishbone master port.
- Pushes data beats into an internal FIFO toward the transfer datapath.
- Reports completion on c_done and releases on the controller's ss_done pulse.

Parameters:
- BURST, 4: maximum beats per Wishbone cycle (cab burst).
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW 64-bit entries.
- RTY_MAX, 15: consecutive rty responses tolerated before abort.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- ss_we  in  1  slot write strobe.
- ss_adr  in  2  slot word index.
- ss_dat  in  32  slot write data.
- ss_dc  in  24  descriptor control word; bit 10 = chain, informational only.
- ss_done  in  1  controller release pulse.
- c_done  out  1  channel finished (data fetched or aborted).
- err  out  3  status: 000 ok, 001 bus err, 010 retry limit.
- wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o  out  1 each  WB master controls.
- wbm_sel_o  out  4  byte select, always 4'b1111.
- wbm_adr_o  out  32  beat address, bits [2:0] = 0.
- wbm_dat_i, wbm_dat64_i  in  32 each  read data, low and high halves.
- wbm_ack_i, wbm_err_i, wbm_rty_i  in  1 each  WB responses.
- dout  out  64  FIFO head {dat64, dat}.
- dout_valid  out  1  FIFO non-empty.
- dout_ready  in  1  consumer pop.
- cyc_cnt  out  32  fetch duration (optional feature).

Behaviour:
- Reset values: all outputs 0. State S_IDLE, FIFO empty.
- Slot words:
  - adr 0: ignored.
  - adr 1: ignored.
  - adr 2: src address; [31:3] latched.
  - adr 3: byte count; [15:0] latched.
  - Any write while not in S_IDLE is ignored.
- Beat count: (cnt+7)>>3, 13-bit.
- States:
  - S_IDLE: ss_we && ss_adr==3 → S_LOAD.
  - S_LOAD: beats==0 → S_DONE; else → S_REQ.
  - S_REQ: wait until FIFO free ≥ min(BURST, remaining beats), then drive cyc/stb/cab=1, we=0 on the next cycle → S_BUS.
  - S_BUS:
    - Each ack (with err=0, rty=0): push {wbm_dat64_i, wbm_dat_i}, address +1 beat, remaining −1.
    - Burst length reached: drop cyc/stb in the same cycle as the last ack. Remaining==0 → S_DRAIN; else → S_REQ.
    - err: drop cyc, err=001 → S_DONE.
    - rty: drop cyc, retry counter +1, re-request the same address via S_REQ. Counter > RTY_MAX → err=010, S_DONE. Counter clears on any ack.
  - S_DRAIN: FIFO empty → S_DONE.
  - S_DONE: c_done=1, held. ss_done → S_IDLE with c_done=0 and err=0 one cycle later.
- Aborted data: on an abort path, FIFO contents are flushed on the cycle of entry to S_DONE.
- Bus addressing: never crosses outside the programmed buffer; the final burst is shortened to the remaining beats.
- FIFO:
  - Simultaneous push and pop when full is legal only because push is gated by the reserved-space check.
  - Pop when empty is ignored.
- ss_done outside S_DONE: forces S_IDLE. cyc drops that cycle and the FIFO is flushed (mid-transfer cancel).
- Reset mid-burst: cyc drops in the next cycle; all state is cleared.
- Address wrap: 29-bit beat address wraps modulo 2^29 with no special handling.

Optional Feature:
- Macro: SS_RD_PERF_CNT_EN.
- Defined:
  - cyc_cnt clears on entry to S_LOAD.
  - Increments every cycle in S_LOAD, S_REQ, S_BUS and S_DRAIN.
  - Freezes in S_DONE; holds through S_IDLE until the next start.
- Undefined: cyc_cnt tied to 0 and the counter logic is absent.

Decomposition:
- Shared package ss_pkg:
  - State encodings.
  - Error codes: SS_ERR_OK=0, SS_ERR_BUS=1, SS_ERR_RTY=2.
  - Slot word indices: SS_W_ADR=2, SS_W_CNT=3.
  - Beat width constant 64.
- Sub-module ss_fifo:
  - Synchronous FIFO, 64-bit, depth 2**FIFO_AW.
  - Provides push, pop, flush, empty and free-count outputs.

Test Plan:
- Basic fetch: write adr2=0x1000, adr3=32, ack every cycle, dout_ready=1 → one 4-beat burst at 0x1000..0x1018. Four beats appear in order, then c_done=1. ss_done → c_done=0 next cycle.
- Length rounding and chunking: cnt=44 → 6 beats issued as a burst of 4 then a burst of 2. The second burst starts at 0x1020.
- Zero length: cnt=0 → no wbm_cyc_o. c_done=1 two cycles after the adr3 write.
- Back-pressure: FIFO_AW=3, dout_ready=0, cnt=128 (16 beats) → at most 8 beats fetched and cyc stays low. Raising dout_ready completes all 16 beats with the data sequence intact.
- Errors:
  - wbm_err_i on beat 2 → cyc drops, err=001, c_done=1, dout_valid=0.
  - 16 consecutive rty → err=010.
- Cancel: ss_done during S_BUS → cyc drops the same cycle, FIFO is empty, state is S_IDLE. With SS_RD_PERF_CNT_EN defined, the basic case gives cyc_cnt = expected cycle count.
